cpu_interrupt_handler: RTL and testbench
========================================

// Module: cpu_interrupt_handler
// PURPOSE
// 6502-style interrupt sequencer for the NES CPU core. On a CPU start request at an instruction
// boundary it performs reset, NMI (PPU vblank), BRK, or RTI sequences: stack pushes/pulls and vector
// fetches over a single 8-bit CPU memory bus. It returns updated PC, status and stack pointer.
// The CPU hands bus ownership to it while accessing_memory is high.
// PARAMETERS
// NMI_VEC  16'hFFFA  NMI vector low-byte address (high byte at +1)
// RST_VEC  16'hFFFC  reset vector low-byte address
// IRQ_VEC  16'hFFFE  BRK/IRQ vector low-byte address
// PORTS
// clk              in   1   system clock, all logic on rising edge
// rst              in   1   synchronous, active-high reset
// cpu_addr         out  16  memory address; 0 when bus not owned
// cpu_data_in      in   8   read data from RAM, valid 1 cycle after cpu_addr (synchronous RAM)
// cpu_data_out     out  8   write data
// write_en         out  1   memory write strobe, 1 cycle per byte
// break_flag       in   1   current instruction is BRK, sampled at start edge
// ppu_status       in   8   PPU status; bit7 rising edge = vblank NMI request
// soft_reset       in   1   active-low soft reset request, level, latched
// is_rti           in   1   current instruction is RTI, sampled at start edge
// start            in   1   request; rising edge (0->1) triggers one sequence
// done             out  1   1-cycle pulse when the sequence completes
// accessing_memory out  1   high while the FSM owns the bus (any state except IDLE/DONE)
// pc_in            in   16  return PC to push (already points past the instruction)
// status_in        in   8   CPU P register (N V - B D I Z C)
// stack_ptr_in     in   16  full stack address (e.g. 16'h01FF), grows down
// pc_out           out  16  resulting PC, registered, holds until the next sequence
// status_out       out  8   resulting P
// stack_ptr_out    out  16  resulting stack address
// BEHAVIOUR
// - While rst is high: FSM=IDLE; all outputs 0; NMI latch cleared; reset_pending=1 (power-on reset).
// - Latches:
//   - soft_reset==0 in any cycle sets reset_pending.
//   - Rising edge of ppu_status[7] sets nmi_pending.
//   - Both latches stay set until serviced.
// - IDLE: on start rising edge, capture pc/status/sp inputs, break_flag and is_rti into working registers.
//   Select the first sequence:
//   1. reset_pending: RESET only. Any RTI/BRK/NMI request is dropped; nmi_pending is cleared too.
//   2. is_rti: RTI.
//   3. break_flag: BRK.
//   4. nmi_pending: NMI.
//   5. Otherwise: DONE directly; outputs = inputs.
// - After an RTI or BRK sequence, if nmi_pending is set, chain an NMI sequence on the updated
//   working registers before DONE.
// - PUSH sequence (BRK/NMI), one write per cycle. Each write puts the byte on cpu_data_out at the
//   current sp with write_en=1, then sp-=1:
//   - PUSH_H writes PC[15:8]; PUSH_L writes PC[7:0]; PUSH_P writes P.
//   - Pushed P = status|0x30 for BRK, (status|0x20)&~0x10 for NMI.
// - VECTOR fetch, 3 cycles:
//   - VEC_L drives the vector address.
//   - VEC_H drives vector+1 and captures the low byte.
//   - VEC_W captures the high byte.
//   - Then set PC=vector, P|=0x04 (I flag), clear the serviced pending bit.
// - RESET: no writes. sp-=3, P|=0x04, vector=RST_VEC, clear reset_pending.
// - RTI, pulls (sp+=1 then read, 2 cycles each):
//   - First pull P: bit4 cleared, bit5 set.
//   - Then PCL, then PCH.
//   - Final sp = entry sp+3.
// - DONE: done=1 for one cycle, outputs valid; return to IDLE. start must fall and rise again to retrigger.
// - Widths: 16-bit wrap-around sp arithmetic; no page-1 forcing.
// - NMI edges arriving mid-sequence are latched, not lost.
// - rst mid-sequence aborts to IDLE with the reset values above.
// TESTING
// - Load RAM FFFA..FFFF = AA,AA,CC,CC,EE,EE. Release rst, start edge, inputs pc=ABCD,p=12,sp=01FF
//   -> RESET: pc_out=CCCC, status_out=16, sp_out=01FC, no writes.
// - Pulse soft_reset=0 for 3 cycles, then start -> second RESET, same vector CCCC.
// - ppu_status=80 (edge), start with pc=ABCD,p=12,sp=01FF -> RAM[01FF]=AB,[01FE]=CD,[01FD]=22;
//   pc_out=AAAA, sp_out=01FC, status_out=16.
// - is_rti=1, status_in=00, sp=01FC, start -> pc_out=ABCD, status_out=22 (not 00), sp_out=01FF.
// - ppu edge pending, then RTI start -> RTI followed by a chained NMI; final pc_out=AAAA, one done pulse.
// - break_flag=1, status_in=04, start -> pushed P=34, pc_out=EEEE, status_out=04, sp_out=sp_in-3.

Source files
------------

// File: rtl/cpu_interrupt_handler.sv
// ---------------------------------------------------------------------------
// cpu_interrupt_handler
// 6502-style interrupt sequencer for the NES CPU core. When the CPU raises
// start at an instruction boundary, this block takes the memory bus and runs
// one of the RESET, NMI, BRK or RTI sequences: stack pushes/pulls and vector
// fetches over a single 8-bit bus backed by synchronous RAM (read data arrives
// one cycle after the address). It then hands back the updated PC, P and SP.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cpu_addr            bus address (0 whenever the bus is not owned)
//   cpu_data_in         RAM read data, valid one cycle after cpu_addr
//   cpu_data_out        write data
//   write_en            write strobe, one cycle per byte
//   break_flag, is_rti  current instruction is BRK / RTI (sampled at start)
//   ppu_status          PPU status; rising edge of bit 7 requests NMI
//   soft_reset          active-low soft reset request (level, latched)
//   start               rising edge triggers one sequence
//   done                one-cycle pulse when the sequence completes
//   accessing_memory    high while the sequencer owns the bus
//   pc_in/status_in/stack_ptr_in     CPU state at the start edge
//   pc_out/status_out/stack_ptr_out  resulting CPU state, held until next run
// ---------------------------------------------------------------------------
module cpu_interrupt_handler #(
   parameter logic [15:0] NMI_VEC = 16'hFFFA,
   parameter logic [15:0] RST_VEC = 16'hFFFC,
   parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data_in,
   output logic [7:0]  cpu_data_out,
   output logic        write_en,
   input  logic        break_flag,
   input  logic [7:0]  ppu_status,
   input  logic        soft_reset,
   input  logic        is_rti,
   input  logic        start,
   output logic        done,
   output logic        accessing_memory,
   input  logic [15:0] pc_in,
   input  logic [7:0]  status_in,
   input  logic [15:0] stack_ptr_in,
   output logic [15:0] pc_out,
   output logic [7:0]  status_out,
   output logic [15:0] stack_ptr_out
);

   typedef enum logic [3:0] {
      S_IDLE, S_PUSH_H, S_PUSH_L, S_PUSH_P, S_VEC_L, S_VEC_H, S_VEC_W,
      S_PULL_P_A, S_PULL_P_R, S_PULL_L_A, S_PULL_L_R, S_PULL_H_A, S_PULL_H_R,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {SEQ_RESET, SEQ_BRK, SEQ_NMI} seq_t;

   state_t      state;
   seq_t        seq;
   logic [15:0] pc_w;
   logic [7:0]  p_w;
   logic [15:0] sp_w;
   logic [15:0] vec;
   logic        start_q;
   logic        ppu7_q;
   logic        nmi_pending;
   logic        reset_pending;

   // Status byte written to the stack: BRK sets B and bit 5, NMI sets bit 5
   // and clears B so the handler can tell the two apart.
   function automatic logic [7:0] pushed_p(input seq_t s, input logic [7:0] p);
      return (s == SEQ_BRK) ? (p | 8'h30) : ((p | 8'h20) & ~8'h10);
   endfunction

   // Every output is registered: each transition drives the bus values that
   // the destination state needs during its own cycle.
   // NOTE: all state here is updated with non-blocking assignments so every
   // branch reads the pre-edge values; later assignments in the block win.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= S_IDLE;
         seq              <= SEQ_RESET;
         pc_w             <= '0;
         p_w              <= '0;
         sp_w             <= '0;
         vec              <= '0;
         start_q          <= 1'b0;
         ppu7_q           <= 1'b0;
         nmi_pending      <= 1'b0;
         reset_pending    <= 1'b1;
         cpu_addr         <= '0;
         cpu_data_out     <= '0;
         write_en         <= 1'b0;
         done             <= 1'b0;
         accessing_memory <= 1'b0;
         pc_out           <= '0;
         status_out       <= '0;
         stack_ptr_out    <= '0;
      end else begin
         start_q          <= start;
         ppu7_q           <= ppu_status[7];
         cpu_addr         <= '0;
         cpu_data_out     <= '0;
         write_en         <= 1'b0;
         done             <= 1'b0;
         accessing_memory <= 1'b1;

         case (state)
            S_IDLE: begin
               accessing_memory <= 1'b0;
               if (start && !start_q) begin
                  pc_w <= pc_in;
                  p_w  <= status_in;
                  sp_w <= stack_ptr_in;
                  if (reset_pending) begin
                     // Reset swallows any other request, including a latched NMI.
                     seq              <= SEQ_RESET;
                     vec              <= RST_VEC;
                     nmi_pending      <= 1'b0;
                     sp_w             <= stack_ptr_in - 16'd3;
                     p_w              <= status_in | 8'h04;
                     cpu_addr         <= RST_VEC;
                     accessing_memory <= 1'b1;
                     state            <= S_VEC_L;
                  end else if (is_rti) begin
                     sp_w             <= stack_ptr_in + 16'd1;
                     cpu_addr         <= stack_ptr_in + 16'd1;
                     accessing_memory <= 1'b1;
                     state            <= S_PULL_P_A;
                  end else if (break_flag || nmi_pending) begin
                     seq              <= break_flag ? SEQ_BRK : SEQ_NMI;
                     vec              <= break_flag ? IRQ_VEC : NMI_VEC;
                     cpu_addr         <= stack_ptr_in;
                     cpu_data_out     <= pc_in[15:8];
                     write_en         <= 1'b1;
                     accessing_memory <= 1'b1;
                     state            <= S_PUSH_H;
                  end else begin
                     pc_out        <= pc_in;
                     status_out    <= status_in;
                     stack_ptr_out <= stack_ptr_in;
                     done          <= 1'b1;
                     state         <= S_DONE;
                  end
               end
            end

            S_PUSH_H: begin
               sp_w         <= sp_w - 16'd1;
               cpu_addr     <= sp_w - 16'd1;
               cpu_data_out <= pc_w[7:0];
               write_en     <= 1'b1;
               state        <= S_PUSH_L;
            end

            S_PUSH_L: begin
               sp_w         <= sp_w - 16'd1;
               cpu_addr     <= sp_w - 16'd1;
               cpu_data_out <= pushed_p(seq, p_w);
               write_en     <= 1'b1;
               state        <= S_PUSH_P;
            end

            S_PUSH_P: begin
               sp_w     <= sp_w - 16'd1;
               cpu_addr <= vec;
               state    <= S_VEC_L;
            end

            S_VEC_L: begin
               cpu_addr <= vec + 16'd1;
               state    <= S_VEC_H;
            end

            S_VEC_H: begin
               pc_w[7:0] <= cpu_data_in;
               state     <= S_VEC_W;
            end

            S_VEC_W: begin
               if (seq == SEQ_RESET) reset_pending <= 1'b0;
               if (seq == SEQ_NMI)   nmi_pending   <= 1'b0;
               if (seq == SEQ_BRK && nmi_pending) begin
                  // Chain the NMI on top of the freshly vectored BRK state.
                  pc_w         <= {cpu_data_in, pc_w[7:0]};
                  p_w          <= p_w | 8'h04;
                  seq          <= SEQ_NMI;
                  vec          <= NMI_VEC;
                  cpu_addr     <= sp_w;
                  cpu_data_out <= cpu_data_in;
                  write_en     <= 1'b1;
                  state        <= S_PUSH_H;
               end else begin
                  pc_out           <= {cpu_data_in, pc_w[7:0]};
                  status_out       <= p_w | 8'h04;
                  stack_ptr_out    <= sp_w;
                  done             <= 1'b1;
                  accessing_memory <= 1'b0;
                  state            <= S_DONE;
               end
            end

            // Each pull: address phase (sp already incremented), then read phase.
            S_PULL_P_A: state <= S_PULL_P_R;

            S_PULL_P_R: begin
               p_w      <= (cpu_data_in & ~8'h10) | 8'h20;
               sp_w     <= sp_w + 16'd1;
               cpu_addr <= sp_w + 16'd1;
               state    <= S_PULL_L_A;
            end

            S_PULL_L_A: state <= S_PULL_L_R;

            S_PULL_L_R: begin
               pc_w[7:0] <= cpu_data_in;
               sp_w      <= sp_w + 16'd1;
               cpu_addr  <= sp_w + 16'd1;
               state     <= S_PULL_H_A;
            end

            S_PULL_H_A: state <= S_PULL_H_R;

            S_PULL_H_R: begin
               if (nmi_pending) begin
                  pc_w         <= {cpu_data_in, pc_w[7:0]};
                  seq          <= SEQ_NMI;
                  vec          <= NMI_VEC;
                  cpu_addr     <= sp_w;
                  cpu_data_out <= cpu_data_in;
                  write_en     <= 1'b1;
                  state        <= S_PUSH_H;
               end else begin
                  pc_out           <= {cpu_data_in, pc_w[7:0]};
                  status_out       <= p_w;
                  stack_ptr_out    <= sp_w;
                  done             <= 1'b1;
                  accessing_memory <= 1'b0;
                  state            <= S_DONE;
               end
            end

            S_DONE: begin
               accessing_memory <= 1'b0;
               state            <= S_IDLE;
            end

            default: begin
               accessing_memory <= 1'b0;
               state            <= S_IDLE;
            end
         endcase

         // Request latches come last so a new request in the same cycle as a
         // service-clear is kept rather than lost.
         if (!soft_reset)                 reset_pending <= 1'b1;
         if (ppu_status[7] && !ppu7_q)    nmi_pending   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cpu_interrupt_handler.sv
// ---------------------------------------------------------------------------
// tb_cpu_interrupt_handler
// Directed bench for cpu_interrupt_handler with a synchronous RAM model. The
// vector page FFFA..FFFF reads AA,AA,CC,CC,EE,EE; the rest is write-back RAM.
// ---------------------------------------------------------------------------
module tb_cpu_interrupt_handler;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_data_in;
   logic [7:0]  cpu_data_out;
   logic        write_en;
   logic        break_flag;
   logic [7:0]  ppu_status;
   logic        soft_reset;
   logic        is_rti;
   logic        start;
   logic        done;
   logic        accessing_memory;
   logic [15:0] pc_in;
   logic [7:0]  status_in;
   logic [15:0] stack_ptr_in;
   logic [15:0] pc_out;
   logic [7:0]  status_out;
   logic [15:0] stack_ptr_out;

   int vectors     = 0;
   int miscompares = 0;
   int wr_count;
   int done_count;
   int acc_cycles;
   int seq_writes;
   int seq_dones;

   logic [7:0] mem [0:65535];

   always #5 clk = ~clk;

   cpu_interrupt_handler dut (
      .clk              (clk),
      .rst              (rst),
      .cpu_addr         (cpu_addr),
      .cpu_data_in      (cpu_data_in),
      .cpu_data_out     (cpu_data_out),
      .write_en         (write_en),
      .break_flag       (break_flag),
      .ppu_status       (ppu_status),
      .soft_reset       (soft_reset),
      .is_rti           (is_rti),
      .start            (start),
      .done             (done),
      .accessing_memory (accessing_memory),
      .pc_in            (pc_in),
      .status_in        (status_in),
      .stack_ptr_in     (stack_ptr_in),
      .pc_out           (pc_out),
      .status_out       (status_out),
      .stack_ptr_out    (stack_ptr_out)
   );

   function automatic logic [7:0] vec_byte(input logic [15:0] a);
      case (a)
         16'hFFFA, 16'hFFFB: return 8'hAA;
         16'hFFFC, 16'hFFFD: return 8'hCC;
         default:            return 8'hEE;
      endcase
   endfunction

   // Synchronous RAM: read data appears the cycle after the address.
   always_ff @(posedge clk) begin
      if (write_en) mem[cpu_addr] <= cpu_data_out;
      cpu_data_in <= (cpu_addr >= 16'hFFFA) ? vec_byte(cpu_addr) : mem[cpu_addr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_count   <= 0;
         done_count <= 0;
      end else begin
         if (write_en) wr_count   <= wr_count + 1;
         if (done)     done_count <= done_count + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Raise start with the given CPU state, wait (bounded) for done, then hold
   // start high a few more cycles so a spurious retrigger would show up as an
   // extra done pulse. nmi_at >= 0 raises ppu_status[7] that many cycles in.
   task automatic run_seq(input string tag, input logic [15:0] pc, input logic [7:0] p,
                          input logic [15:0] sp, input logic brk, input logic rti,
                          input int nmi_at);
      int  wr0;
      int  dn0;
      bit  seen;
      @(negedge clk);
      pc_in        = pc;
      status_in    = p;
      stack_ptr_in = sp;
      break_flag   = brk;
      is_rti       = rti;
      start        = 1'b1;
      wr0          = wr_count;
      dn0          = done_count;
      acc_cycles   = 0;
      seen         = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         if (c == nmi_at) ppu_status = 8'h80;
         if (done) seen = 1'b1;
         else if (accessing_memory) acc_cycles++;
      end
      check({tag, " done seen"}, 32'(seen), 32'd1);
      seq_writes = wr_count - wr0;
      repeat (3) @(negedge clk);
      seq_dones  = done_count - dn0;
      start      = 1'b0;
      break_flag = 1'b0;
      is_rti     = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      break_flag   = 1'b0;
      ppu_status   = 8'h00;
      soft_reset   = 1'b1;
      is_rti       = 1'b0;
      start        = 1'b0;
      pc_in        = 16'h0;
      status_in    = 8'h0;
      stack_ptr_in = 16'h0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst pc_out",   32'(pc_out), 32'h0);
      check("rst status",   32'(status_out), 32'h0);
      check("rst sp",       32'(stack_ptr_out), 32'h0);
      check("rst done",     32'(done), 32'h0);
      check("rst access",   32'(accessing_memory), 32'h0);
      check("rst addr",     32'(cpu_addr), 32'h0);
      check("rst we",       32'(write_en), 32'h0);
      rst = 1'b0;

      // Power-on RESET
      run_seq("por", 16'hABCD, 8'h12, 16'h01FF, 1'b0, 1'b0, -1);
      check("por pc",     32'(pc_out), 32'hCCCC);
      check("por status", 32'(status_out), 32'h16);
      check("por sp",     32'(stack_ptr_out), 32'h01FC);
      check("por writes", 32'(seq_writes), 32'd0);
      check("por access", 32'(acc_cycles), 32'd3);
      check("por dones",  32'(seq_dones), 32'd1);

      // Soft reset held low for 3 cycles
      soft_reset = 1'b0;
      repeat (3) @(negedge clk);
      soft_reset = 1'b1;
      run_seq("soft", 16'h1234, 8'h80, 16'h0100, 1'b0, 1'b0, -1);
      check("soft pc",     32'(pc_out), 32'hCCCC);
      check("soft status", 32'(status_out), 32'h84);
      check("soft sp",     32'(stack_ptr_out), 32'h00FD);
      check("soft writes", 32'(seq_writes), 32'd0);

      // NMI from a PPU vblank edge
      ppu_status = 8'h80;
      run_seq("nmi", 16'hABCD, 8'h12, 16'h01FF, 1'b0, 1'b0, -1);
      check("nmi ram1ff", 32'(mem[16'h01FF]), 32'hAB);
      check("nmi ram1fe", 32'(mem[16'h01FE]), 32'hCD);
      check("nmi ram1fd", 32'(mem[16'h01FD]), 32'h22);
      check("nmi pc",     32'(pc_out), 32'hAAAA);
      check("nmi sp",     32'(stack_ptr_out), 32'h01FC);
      check("nmi status", 32'(status_out), 32'h16);
      check("nmi writes", 32'(seq_writes), 32'd3);
      check("nmi access", 32'(acc_cycles), 32'd6);

      // RTI unwinds that frame
      run_seq("rti", 16'h0000, 8'h00, 16'h01FC, 1'b0, 1'b1, -1);
      check("rti pc",     32'(pc_out), 32'hABCD);
      check("rti status", 32'(status_out), 32'h22);
      check("rti sp",     32'(stack_ptr_out), 32'h01FF);
      check("rti writes", 32'(seq_writes), 32'd0);
      check("rti access", 32'(acc_cycles), 32'd6);

      // Pending NMI chained after RTI
      ppu_status = 8'h00;
      @(negedge clk);
      ppu_status = 8'h80;
      run_seq("rtinmi", 16'h0000, 8'h00, 16'h01FC, 1'b0, 1'b1, -1);
      check("rtinmi pc",     32'(pc_out), 32'hAAAA);
      check("rtinmi status", 32'(status_out), 32'h26);
      check("rtinmi sp",     32'(stack_ptr_out), 32'h01FC);
      check("rtinmi ram1fd", 32'(mem[16'h01FD]), 32'h22);
      check("rtinmi writes", 32'(seq_writes), 32'd3);
      check("rtinmi access", 32'(acc_cycles), 32'd12);
      check("rtinmi dones",  32'(seq_dones), 32'd1);

      // BRK
      run_seq("brk", 16'h2000, 8'h04, 16'h01F0, 1'b1, 1'b0, -1);
      check("brk ram1f0", 32'(mem[16'h01F0]), 32'h20);
      check("brk ram1ef", 32'(mem[16'h01EF]), 32'h00);
      check("brk ram1ee", 32'(mem[16'h01EE]), 32'h34);
      check("brk pc",     32'(pc_out), 32'hEEEE);
      check("brk status", 32'(status_out), 32'h04);
      check("brk sp",     32'(stack_ptr_out), 32'h01ED);

      // Reset pending together with an NMI: only RESET runs, NMI is dropped
      ppu_status = 8'h00;
      @(negedge clk);
      ppu_status = 8'h80;
      soft_reset = 1'b0;
      @(negedge clk);
      soft_reset = 1'b1;
      run_seq("rstnmi", 16'h5555, 8'h00, 16'h0180, 1'b0, 1'b0, -1);
      check("rstnmi pc",     32'(pc_out), 32'hCCCC);
      check("rstnmi status", 32'(status_out), 32'h04);
      check("rstnmi sp",     32'(stack_ptr_out), 32'h017D);
      run_seq("idle", 16'h4321, 8'hC3, 16'h01AA, 1'b0, 1'b0, -1);
      check("idle pc",     32'(pc_out), 32'h4321);
      check("idle status", 32'(status_out), 32'hC3);
      check("idle sp",     32'(stack_ptr_out), 32'h01AA);
      check("idle access", 32'(acc_cycles), 32'd0);
      check("idle writes", 32'(seq_writes), 32'd0);

      // NMI edge arriving mid-BRK is latched and chained
      ppu_status = 8'h00;
      run_seq("brknmi", 16'h3000, 8'h00, 16'h01FF, 1'b1, 1'b0, 1);
      check("brknmi ram1fd", 32'(mem[16'h01FD]), 32'h30);
      check("brknmi ram1fc", 32'(mem[16'h01FC]), 32'hEE);
      check("brknmi ram1fa", 32'(mem[16'h01FA]), 32'h24);
      check("brknmi pc",     32'(pc_out), 32'hAAAA);
      check("brknmi status", 32'(status_out), 32'h04);
      check("brknmi sp",     32'(stack_ptr_out), 32'h01F9);
      check("brknmi writes", 32'(seq_writes), 32'd6);
      check("brknmi dones",  32'(seq_dones), 32'd1);

      // rst mid-sequence aborts and re-arms the power-on reset
      @(negedge clk);
      pc_in        = 16'h7777;
      status_in    = 8'h00;
      stack_ptr_in = 16'h01FF;
      break_flag   = 1'b1;
      start        = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort pc",     32'(pc_out), 32'h0);
      check("abort access", 32'(accessing_memory), 32'h0);
      check("abort we",     32'(write_en), 32'h0);
      check("abort addr",   32'(cpu_addr), 32'h0);
      rst        = 1'b0;
      start      = 1'b0;
      break_flag = 1'b0;
      run_seq("post", 16'h9999, 8'h01, 16'h01FF, 1'b1, 1'b0, -1);
      check("post pc",     32'(pc_out), 32'hCCCC);
      check("post status", 32'(status_out), 32'h05);
      check("post sp",     32'(stack_ptr_out), 32'h01FC);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
